// File: rtl/mips_bus_pkg.sv
// Shared types and widths for the Harvard CPU bus arbiter and its helpers.
package mips_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        GNT_I,
        GNT_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } grant_t;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-cycle counter for a granted bus transaction; expired pulses on the LIMIT-th wait cycle.
// LIMIT = 0 disables expiry entirely (the counter still runs but never fires).
module bus_timeout_ctr #(
    parameter int unsigned LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires in the cycle that would bring the count to LIMIT, so at most LIMIT wait cycles occur.
    assign expired = (LIMIT > 0) && enable && (count == LAST);

endmodule

// File: rtl/harvard_bus_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one Avalon-style bus, one transaction at a time.
// Optional ARB_ROUND_ROBIN_EN replaces fixed data-first priority with alternating grants.
module harvard_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 0,
    parameter logic [DATA_W-1:0] ERR_READDATA   = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_read,
    input  logic [ADDR_W-1:0] instr_address,
    output logic [DATA_W-1:0] instr_readdata,
    output logic              instr_waitrequest,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [DATA_W-1:0] data_writedata,
    input  logic [3:0]        data_byteenable,
    output logic [DATA_W-1:0] data_readdata,
    output logic              data_waitrequest,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_writedata,
    output logic [3:0]        bus_byteenable,
    input  logic [DATA_W-1:0] bus_readdata,
    input  logic              bus_waitrequest,
    output logic              bus_error
);

    arb_state_t        state;
    logic              data_req;
    logic              grant_data;
    logic              in_gnt;
    logic              tmo_expired;
    logic [DATA_W-1:0] resp_data;

    assign data_req = data_read | data_write;
    assign in_gnt   = (state == GNT_I) || (state == GNT_D);

`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_grant;
    assign grant_data = data_req & (~instr_read | (last_grant == GRANT_INSTR));
`else
    assign grant_data = data_req;
`endif

    // Completion only happens with waitrequest high when the timeout fired.
    assign resp_data = bus_waitrequest ? ERR_READDATA : bus_readdata;

    assign instr_waitrequest = instr_read & (state != RESP_I);
    assign data_waitrequest  = data_req & (state != RESP_D);

    bus_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (~in_gnt),
        .enable (in_gnt & bus_waitrequest),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_error      <= 1'b0;
            bus_address    <= '0;
            bus_writedata  <= '0;
            bus_byteenable <= '0;
            instr_readdata <= '0;
            data_readdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant     <= GRANT_INSTR;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state          <= GNT_D;
                        bus_address    <= data_address;
                        bus_writedata  <= data_writedata;
                        bus_byteenable <= data_byteenable;
                        bus_write      <= data_write;
                        bus_read       <= data_read & ~data_write;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant     <= GRANT_DATA;
`endif
                    end else if (instr_read) begin
                        state          <= GNT_I;
                        bus_address    <= instr_address;
                        bus_writedata  <= '0;
                        bus_byteenable <= BYTEEN_ALL;
                        bus_write      <= 1'b0;
                        bus_read       <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant     <= GRANT_INSTR;
`endif
                    end
                end
                GNT_I, GNT_D: begin
                    if (!bus_waitrequest || tmo_expired) begin
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        state     <= (state == GNT_I) ? RESP_I : RESP_D;
                        if (bus_read) begin
                            if (state == GNT_I) begin
                                instr_readdata <= resp_data;
                            end else begin
                                data_readdata <= resp_data;
                            end
                        end
                        if (bus_waitrequest) begin
                            bus_error <= 1'b1;
                        end
                    end
                end
                RESP_I, RESP_D: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harvard_bus_arbiter.sv
// Randomized bench for harvard_bus_arbiter against a transaction-level timing model.
`timescale 1ns/1ps
module tb_harvard_bus_arbiter;

    localparam int          TMO    = 8;
    localparam logic [31:0] ERR_RD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_waitrequest;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_waitrequest;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;
    logic        bus_error;

    int          checks = 0;
    int          errors = 0;
    int          mem_wait = 0;
    int          wait_seen;
    logic [31:0] ovr_addr = 32'h0000_0001;
    logic [31:0] ovr_data = 32'h0;
    bit          model_last_data = 1'b0;

    harvard_bus_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_READDATA  (ERR_RD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_read       (instr_read),
        .instr_address    (instr_address),
        .instr_readdata   (instr_readdata),
        .instr_waitrequest(instr_waitrequest),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_address     (data_address),
        .data_writedata   (data_writedata),
        .data_byteenable  (data_byteenable),
        .data_readdata    (data_readdata),
        .data_waitrequest (data_waitrequest),
        .bus_address      (bus_address),
        .bus_read         (bus_read),
        .bus_write        (bus_write),
        .bus_writedata    (bus_writedata),
        .bus_byteenable   (bus_byteenable),
        .bus_readdata     (bus_readdata),
        .bus_waitrequest  (bus_waitrequest),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    // Memory stub: each transaction stalls for mem_wait cycles, data is a function of the address.
    assign bus_waitrequest = (bus_read | bus_write) && (wait_seen < mem_wait);
    assign bus_readdata    = (bus_address == ovr_addr) ? ovr_data
                           : {bus_address[15:0] ^ 16'hA5C3, bus_address[31:16] + 16'h1357};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_seen <= 0;
        end else if ((bus_read | bus_write) && bus_waitrequest) begin
            wait_seen <= wait_seen + 1;
        end else begin
            wait_seen <= 0;
        end
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == ovr_addr) return ovr_data;
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
    endfunction

    task automatic idle_inputs();
        instr_read      = 1'b0;
        instr_address   = '0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = '0;
        data_writedata  = '0;
        data_byteenable = '0;
    endtask

    // Runs one arbitration round: each requester holds its request until its RESP cycle.
    // Every transaction costs IDLE + GNT(1 + waits, capped by timeout) + RESP cycles.
    task automatic do_txn(input string name, input bit i_req, input logic [31:0] i_addr,
                          input bit d_rd, input bit d_wr, input logic [31:0] d_addr,
                          input logic [31:0] d_wdata, input logic [3:0] d_be, input int waits);
        bit d_req;
        bit d_is_rd;
        bit tmo;
        bit data_first;
        bit in_i;
        bit in_d;
        int lat;
        int i_done;
        int d_done;
        int last_c;
        logic [31:0] exp_rd;
        d_req   = d_rd | d_wr;
        d_is_rd = d_rd & ~d_wr;
        tmo     = (waits >= TMO);
        lat     = tmo ? TMO + 1 : waits + 2;
        mem_wait = waits;
`ifdef ARB_ROUND_ROBIN_EN
        data_first = (i_req && d_req) ? !model_last_data : d_req;
`else
        data_first = d_req;
`endif
        i_done = -1;
        d_done = -1;
        if (i_req) i_done = (d_req && data_first) ? 2 * lat + 1 : lat;
        if (d_req) d_done = (i_req && !data_first) ? 2 * lat + 1 : lat;
        if (i_req && d_req) model_last_data = !data_first;
        else if (d_req) model_last_data = 1'b1;
        else if (i_req) model_last_data = 1'b0;
        last_c = ((i_done > d_done) ? i_done : d_done) + 1;

        for (int c = 0; c <= last_c; c++) begin
            instr_read      = i_req && (c <= i_done);
            instr_address   = i_addr;
            data_read       = d_rd && (c <= d_done);
            data_write      = d_wr && (c <= d_done);
            data_address    = d_addr;
            data_writedata  = d_wdata;
            data_byteenable = d_be;
            #1;
            in_i = i_req && (c >= i_done - lat + 1) && (c <= i_done - 1);
            in_d = d_req && (c >= d_done - lat + 1) && (c <= d_done - 1);

            checks++;
            if (instr_waitrequest !== (i_req && c < i_done)) begin
                errors++;
                $display("FAIL %s instr_waitrequest c=%0d: got %b want %b", name, c,
                         instr_waitrequest, (i_req && c < i_done));
            end
            checks++;
            if (data_waitrequest !== (d_req && c < d_done)) begin
                errors++;
                $display("FAIL %s data_waitrequest c=%0d: got %b want %b", name, c,
                         data_waitrequest, (d_req && c < d_done));
            end
            checks++;
            if (bus_read !== (in_i || (in_d && d_is_rd)) || bus_write !== (in_d && d_wr)) begin
                errors++;
                $display("FAIL %s strobes c=%0d: got rd=%b wr=%b want rd=%b wr=%b", name, c,
                         bus_read, bus_write, (in_i || (in_d && d_is_rd)), (in_d && d_wr));
            end
            if (in_i) begin
                checks++;
                if (bus_address !== i_addr || bus_byteenable !== 4'hF) begin
                    errors++;
                    $display("FAIL %s instr bus c=%0d: got a=%h be=%h want a=%h be=f", name, c,
                             bus_address, bus_byteenable, i_addr);
                end
            end
            if (in_d) begin
                checks++;
                if (bus_address !== d_addr || bus_byteenable !== d_be ||
                    (d_wr && bus_writedata !== d_wdata)) begin
                    errors++;
                    $display("FAIL %s data bus c=%0d: got a=%h be=%h wd=%h want a=%h be=%h wd=%h",
                             name, c, bus_address, bus_byteenable, bus_writedata, d_addr, d_be, d_wdata);
                end
            end
            if (i_req && c == i_done) begin
                exp_rd = tmo ? ERR_RD : mem_fn(i_addr);
                checks++;
                if (instr_readdata !== exp_rd) begin
                    errors++;
                    $display("FAIL %s instr_readdata: got %h want %h", name, instr_readdata, exp_rd);
                end
            end
            if (d_is_rd && c == d_done) begin
                exp_rd = tmo ? ERR_RD : mem_fn(d_addr);
                checks++;
                if (data_readdata !== exp_rd) begin
                    errors++;
                    $display("FAIL %s data_readdata: got %h want %h", name, data_readdata, exp_rd);
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_read !== 1'b0 || bus_write !== 1'b0 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL reset strobes: got rd=%b wr=%b err=%b want 0", bus_read, bus_write, bus_error);
        end
        checks++;
        if (bus_address !== 32'h0 || bus_writedata !== 32'h0 || bus_byteenable !== 4'h0) begin
            errors++;
            $display("FAIL reset bus regs: got a=%h wd=%h be=%h want 0", bus_address, bus_writedata,
                     bus_byteenable);
        end
        checks++;
        if (instr_readdata !== 32'h0 || data_readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset readdata: got i=%h d=%h want 0", instr_readdata, data_readdata);
        end
        checks++;
        if (instr_waitrequest !== 1'b0 || data_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset waitrequest: got i=%b d=%b want 0", instr_waitrequest, data_waitrequest);
        end
        reset = 1'b1;
        model_last_data = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch();
        ovr_addr = 32'hBFC0_0000;
        ovr_data = 32'h2402_0005;
        do_txn("fetch", 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    endtask

    task automatic test_simultaneous();
        do_txn("simul", 1'b1, 32'hBFC0_0004, 1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0);
    endtask

    task automatic test_wait_load();
        ovr_addr = 32'h0000_2000;
        ovr_data = 32'h0000_00AB;
        do_txn("wait_load", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 4);
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_0", 1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h3, 1);
        do_txn("b2b_1", 1'b1, 32'h0040_0004, 1'b0, 1'b1, 32'h0000_3004, 32'h1234_5678, 4'hC, 0);
        do_txn("b2b_2", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3008, 32'hCAFE_F00D, 4'h5, 2);
        do_txn("b2b_3", 1'b1, 32'h0040_0008, 1'b1, 1'b0, 32'h0000_300C, 32'h0, 4'hF, 0);
    endtask

    task automatic test_random();
        bit          ir;
        bit          dr;
        bit          dw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [3:0]  be;
        int          w;
        ovr_addr = 32'h0000_0001;
        for (int n = 0; n < 40; n++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw) ir = 1'b1;
            ia = $urandom & 32'hFFFF_FFFC;
            da = $urandom & 32'hFFFF_FFFC;
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            w  = $urandom_range(0, 5);
            do_txn("random", ir, ia, dr, dw, da, wd, be, w);
        end
    endtask

    task automatic test_timeout();
        do_txn("timeout", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 1000);
        checks++;
        if (bus_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout bus_error: got %b want 1", bus_error);
        end
        do_txn("after_timeout", 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
        checks++;
        if (bus_error !== 1'b1) begin
            errors++;
            $display("FAIL sticky bus_error: got %b want 1", bus_error);
        end
    endtask

    task automatic test_async_reset();
        mem_wait      = 1000;
        instr_read    = 1'b1;
        instr_address = 32'h0040_0200;
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (bus_read !== 1'b1) begin
            errors++;
            $display("FAIL async_reset pre grant: got bus_read=%b want 1", bus_read);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus_read !== 1'b0 || bus_error !== 1'b0 || data_readdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset clear: got rd=%b err=%b drd=%h want 0 0 0", bus_read,
                     bus_error, data_readdata);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_last_data = 1'b0;
        @(posedge clk);
        #1;
        do_txn("post_reset", 1'b1, 32'h0040_0204, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_wait_load();
        test_back_to_back();
        test_random();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
